// File: rtl/bus_master_ctrl.sv
// ============================================================================
// bus_master_ctrl
// ----------------------------------------------------------------------------
// Initiator-side controller for the shared 4-master/8-slave bus. Turns a
// single-cycle core access request into a full bus transaction: request/grant
// handshake with the arbiter, one-cycle address strobe, wait for slave ready,
// then return read data and a one-cycle completion pulse to the core.
//
// Optional feature macro: BUS_TIMEOUT_EN
//   defined   : an 8-bit counter aborts a transfer after TIMEOUT_CYCLES cycles
//               in ACCESS+WAIT without slave ready (core_err=1, data=0).
//   undefined : no counter, core_err tied to 0, WAIT lasts until m_rdy_=0.
//
// Parameters
//   TIMEOUT_CYCLES  cycles in ACCESS+WAIT before abort (1..255)
//
// Ports
//   clk, reset         clock, asynchronous active-high reset
//   core_req           access request, sampled only in IDLE
//   core_addr[29:0]    word address        core_rw       1=read 0=write
//   core_wr_data[31:0] write data
//   core_rd_data[31:0] read data, valid while core_done=1
//   core_busy          1 whenever state is not IDLE
//   core_done          one-cycle completion pulse
//   core_err           qualifies core_done, 1 = aborted
//   m_req_ / m_grnt_   bus request / grant, active-low
//   m_addr, m_rw, m_wr_data   bus address, direction, write data
//   m_as_              address strobe, active-low
//   m_rd_data, m_rdy_  read data from slave mux, slave ready (active-low)
//   dbg_state[1:0]     current FSM state (0 IDLE, 1 REQ, 2 ACCESS, 3 WAIT)
//
// Core handshake: core_req is a single-cycle strobe honoured only while
// core_busy=0; the result is delivered by exactly one core_done pulse, in the
// same cycle core_busy falls. Requests seen while busy are dropped.
// ============================================================================
module bus_master_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_req,
    input  logic [29:0] core_addr,
    input  logic        core_rw,
    input  logic [31:0] core_wr_data,
    output logic [31:0] core_rd_data,
    output logic        core_busy,
    output logic        core_done,
    output logic        core_err,
    output logic        m_req_,
    input  logic        m_grnt_,
    output logic [29:0] m_addr,
    output logic        m_as_,
    output logic        m_rw,
    output logic [31:0] m_wr_data,
    input  logic [31:0] m_rd_data,
    input  logic        m_rdy_,
    output logic [1:0]  dbg_state
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("bus_master_ctrl: TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACCESS = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_req_n, w_req_n;
    logic        r_as_n, w_as_n;
    logic        r_rw, w_rw;
    logic [29:0] r_addr, w_addr;
    logic [31:0] r_wr_data, w_wr_data;
    logic [31:0] r_rd_data, w_rd_data;
    logic        r_busy, w_busy;
    logic        r_done, w_done;

`ifdef BUS_TIMEOUT_EN
    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic        r_err, w_err;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_req_n   <= 1'b1;
            r_as_n    <= 1'b1;
            r_rw      <= 1'b1;
            r_addr    <= '0;
            r_wr_data <= '0;
            r_rd_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_req_n   <= w_req_n;
            r_as_n    <= w_as_n;
            r_rw      <= w_rw;
            r_addr    <= w_addr;
            r_wr_data <= w_wr_data;
            r_rd_data <= w_rd_data;
            r_busy    <= w_busy;
            r_done    <= w_done;
        end
    end

`ifdef BUS_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_err <= w_err;
        end
    end
`endif

    // Outputs are computed one cycle ahead from the next state so that every
    // bus and core output comes straight from a flop.
    always_comb begin
        w_state_nxt = r_state;
        w_req_n     = r_req_n;
        w_as_n      = 1'b1;
        w_rw        = r_rw;
        w_addr      = r_addr;
        w_wr_data   = r_wr_data;
        w_rd_data   = r_rd_data;
        w_busy      = r_busy;
        w_done      = 1'b0;
`ifdef BUS_TIMEOUT_EN
        w_cnt_nxt   = r_cnt;
        w_err       = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                // m_req_ is always high for the IDLE cycle after completion,
                // which leaves other masters an arbitration slot.
                w_req_n = 1'b1;
                w_busy  = 1'b0;
                if (core_req) begin
                    w_addr      = core_addr;
                    w_rw        = core_rw;
                    w_wr_data   = core_wr_data;
                    w_req_n     = 1'b0;
                    w_busy      = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!m_grnt_) begin
                    w_as_n      = 1'b0;
                    w_state_nxt = ST_ACCESS;
`ifdef BUS_TIMEOUT_EN
                    w_cnt_nxt   = '0;
`endif
                end
            end
            ST_ACCESS, ST_WAIT: begin
                if (!m_rdy_) begin
                    w_req_n     = 1'b1;
                    w_busy      = 1'b0;
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                    if (r_rw) begin
                        w_rd_data = m_rd_data;
                    end
`ifdef BUS_TIMEOUT_EN
                end else if (r_cnt == LP_CNT_LAST) begin
                    // Ready on the final count cycle wins over the abort above.
                    w_req_n     = 1'b1;
                    w_busy      = 1'b0;
                    w_done      = 1'b1;
                    w_err       = 1'b1;
                    w_rd_data   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt + 8'd1;
                    w_state_nxt = ST_WAIT;
`else
                end else begin
                    w_state_nxt = ST_WAIT;
`endif
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign core_rd_data = r_rd_data;
    assign core_busy    = r_busy;
    assign core_done    = r_done;
    assign m_req_       = r_req_n;
    assign m_addr       = r_addr;
    assign m_as_        = r_as_n;
    assign m_rw         = r_rw;
    assign m_wr_data    = r_wr_data;
    assign dbg_state    = r_state;
`ifdef BUS_TIMEOUT_EN
    assign core_err     = r_err;
`else
    assign core_err     = 1'b0;
`endif

endmodule

// File: tb/tb_bus_master_ctrl.sv
// ============================================================================
// tb_bus_master_ctrl
// Directed table-driven bench for bus_master_ctrl (TIMEOUT_CYCLES = 4), with
// hand-written sequences for grant delay, reset in WAIT and timeout.
// ============================================================================
module tb_bus_master_ctrl;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_ACC  = 2'd2;
    localparam logic [1:0] S_WAIT = 2'd3;

    logic        clk;
    logic        reset;
    logic        core_req;
    logic [29:0] core_addr;
    logic        core_rw;
    logic [31:0] core_wr_data;
    logic [31:0] core_rd_data;
    logic        core_busy;
    logic        core_done;
    logic        core_err;
    logic        m_req_;
    logic        m_grnt_;
    logic [29:0] m_addr;
    logic        m_as_;
    logic        m_rw;
    logic [31:0] m_wr_data;
    logic [31:0] m_rd_data;
    logic        m_rdy_;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    bus_master_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_addr(core_addr), .core_rw(core_rw),
        .core_wr_data(core_wr_data), .core_rd_data(core_rd_data),
        .core_busy(core_busy), .core_done(core_done), .core_err(core_err),
        .m_req_(m_req_), .m_grnt_(m_grnt_), .m_addr(m_addr), .m_as_(m_as_),
        .m_rw(m_rw), .m_wr_data(m_wr_data), .m_rd_data(m_rd_data),
        .m_rdy_(m_rdy_), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic        req;
        logic [29:0] addr;
        logic        rw;
        logic [31:0] wd;
        logic        gn;
        logic        rn;
        logic [31:0] rd;
        logic [1:0]  e_state;
        logic        e_req_n;
        logic        e_as_n;
        logic        e_busy;
        logic        e_done;
        logic [31:0] e_rd;
        logic [29:0] e_addr;
        logic        e_rw;
        logic [31:0] e_wd;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(
        input logic req, input logic [29:0] addr, input logic rw, input logic [31:0] wd,
        input logic gn, input logic rn, input logic [31:0] rd,
        input logic [1:0] st, input logic rqn, input logic asn, input logic busy,
        input logic done, input logic [31:0] erd, input logic [29:0] eaddr,
        input logic erw, input logic [31:0] ewd);
        vec_t v;
        v.req = req; v.addr = addr; v.rw = rw; v.wd = wd;
        v.gn = gn; v.rn = rn; v.rd = rd;
        v.e_state = st; v.e_req_n = rqn; v.e_as_n = asn; v.e_busy = busy;
        v.e_done = done; v.e_rd = erd; v.e_addr = eaddr; v.e_rw = erw; v.e_wd = ewd;
        vecs.push_back(v);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        core_req = 1'b0; core_addr = '0; core_rw = 1'b0; core_wr_data = '0;
        m_grnt_ = 1'b1; m_rdy_ = 1'b1; m_rd_data = '0;
    endtask

    // Issue a request, grant one cycle after m_req_, return just after the
    // edge that enters ACCESS.
    task automatic start_txn(input logic [29:0] a, input logic rw, input logic [31:0] wd);
        core_req = 1'b1; core_addr = a; core_rw = rw; core_wr_data = wd;
        m_grnt_ = 1'b1; m_rdy_ = 1'b1;
        step();
        core_req = 1'b0;
        step();
        m_grnt_ = 1'b0;
        step();
        chk("start_access_state", 32'(dbg_state), 32'(S_ACC));
    endtask

    // Bounded wait for core_done, then scoreboard the read data.
    task automatic wait_done(input string name, input int budget);
        logic [31:0] exp;
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (core_done) begin
                seen = 1'b1;
                break;
            end
        end
        chk({name, "_done_seen"}, 32'(seen), 32'd1);
        if (seen && exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            chk({name, "_rd_data"}, core_rd_data, exp);
        end
    endtask

    // ---------------- test body ----------------
    initial begin
        reset = 1'b1;
        drive_idle();

        // Read, zero wait, grant after edge 1; rdy_ low in REQ is ignored.
        add_vec(1, 30'h1234, 1, 32'h0,  1, 1, 32'h0,        S_REQ,  0, 1, 1, 0, 32'h0,        30'h1234, 1, 32'h0);
        add_vec(0, 30'h0,    0, 32'h0,  1, 0, 32'h0,        S_REQ,  0, 1, 1, 0, 32'h0,        30'h1234, 1, 32'h0);
        add_vec(0, 30'h0,    0, 32'h0,  0, 1, 32'h0,        S_ACC,  0, 0, 1, 0, 32'h0,        30'h1234, 1, 32'h0);
        add_vec(0, 30'h0,    0, 32'h0,  0, 0, 32'hDEADBEEF, S_IDLE, 1, 1, 0, 1, 32'hDEADBEEF, 30'h1234, 1, 32'h0);
        add_vec(0, 30'h0,    0, 32'h0,  1, 1, 32'h0,        S_IDLE, 1, 1, 0, 0, 32'hDEADBEEF, 30'h1234, 1, 32'h0);
        // Write with 3 slave wait cycles; rd_data keeps the previous read.
        add_vec(1, 30'h2A0,  0, 32'hA5A55A5A, 1, 1, 32'h0,  S_REQ,  0, 1, 1, 0, 32'hDEADBEEF, 30'h2A0, 0, 32'hA5A55A5A);
        add_vec(0, 30'h0,    0, 32'h0,  1, 1, 32'h0,        S_REQ,  0, 1, 1, 0, 32'hDEADBEEF, 30'h2A0, 0, 32'hA5A55A5A);
        add_vec(0, 30'h0,    0, 32'h0,  0, 1, 32'h0,        S_ACC,  0, 0, 1, 0, 32'hDEADBEEF, 30'h2A0, 0, 32'hA5A55A5A);
        add_vec(0, 30'h0,    0, 32'h0,  0, 1, 32'h0,        S_WAIT, 0, 1, 1, 0, 32'hDEADBEEF, 30'h2A0, 0, 32'hA5A55A5A);
        add_vec(0, 30'h0,    0, 32'h0,  0, 1, 32'h0,        S_WAIT, 0, 1, 1, 0, 32'hDEADBEEF, 30'h2A0, 0, 32'hA5A55A5A);
        add_vec(0, 30'h0,    0, 32'h0,  0, 1, 32'h0,        S_WAIT, 0, 1, 1, 0, 32'hDEADBEEF, 30'h2A0, 0, 32'hA5A55A5A);
        add_vec(0, 30'h0,    0, 32'h0,  0, 0, 32'h11112222, S_IDLE, 1, 1, 0, 1, 32'hDEADBEEF, 30'h2A0, 0, 32'hA5A55A5A);
        add_vec(0, 30'h0,    0, 32'h0,  1, 1, 32'h0,        S_IDLE, 1, 1, 0, 0, 32'hDEADBEEF, 30'h2A0, 0, 32'hA5A55A5A);
        // Grant and ready in IDLE with no request: nothing happens.
        add_vec(0, 30'h0,    0, 32'h0,  0, 0, 32'h0,        S_IDLE, 1, 1, 0, 0, 32'hDEADBEEF, 30'h2A0, 0, 32'hA5A55A5A);

        step();
        step();
        // Reset values
        chk("rst_state",   32'(dbg_state), 32'(S_IDLE));
        chk("rst_m_req_",  32'(m_req_), 32'd1);
        chk("rst_m_as_",   32'(m_as_), 32'd1);
        chk("rst_m_rw",    32'(m_rw), 32'd1);
        chk("rst_m_addr",  32'(m_addr), 32'd0);
        chk("rst_m_wd",    m_wr_data, 32'd0);
        chk("rst_rd_data", core_rd_data, 32'd0);
        chk("rst_busy",    32'(core_busy), 32'd0);
        chk("rst_done",    32'(core_done), 32'd0);
        chk("rst_err",     32'(core_err), 32'd0);
        reset = 1'b0;
        step();

        // ---- table ----
        foreach (vecs[i]) begin
            core_req = vecs[i].req; core_addr = vecs[i].addr; core_rw = vecs[i].rw;
            core_wr_data = vecs[i].wd; m_grnt_ = vecs[i].gn; m_rdy_ = vecs[i].rn;
            m_rd_data = vecs[i].rd;
            step();
            chk($sformatf("vec%0d_state", i), 32'(dbg_state), 32'(vecs[i].e_state));
            chk($sformatf("vec%0d_m_req_", i), 32'(m_req_), 32'(vecs[i].e_req_n));
            chk($sformatf("vec%0d_m_as_", i), 32'(m_as_), 32'(vecs[i].e_as_n));
            chk($sformatf("vec%0d_busy", i), 32'(core_busy), 32'(vecs[i].e_busy));
            chk($sformatf("vec%0d_done", i), 32'(core_done), 32'(vecs[i].e_done));
            chk($sformatf("vec%0d_err", i), 32'(core_err), 32'd0);
            chk($sformatf("vec%0d_rd_data", i), core_rd_data, vecs[i].e_rd);
            chk($sformatf("vec%0d_m_addr", i), 32'(m_addr), 32'(vecs[i].e_addr));
            chk($sformatf("vec%0d_m_rw", i), 32'(m_rw), 32'(vecs[i].e_rw));
            chk($sformatf("vec%0d_m_wd", i), m_wr_data, vecs[i].e_wd);
        end
        drive_idle();
        step();

        // ---- grant delayed 5 cycles, core_req held high throughout ----
        core_req = 1'b1; core_addr = 30'h3C0; core_rw = 1'b1; core_wr_data = 32'h0;
        step();
        chk("gd_req_low", 32'(m_req_), 32'd0);
        core_addr = 30'h777;  // second request while busy must be ignored
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("gd_wait%0d_as", i), 32'(m_as_), 32'd1);
            chk($sformatf("gd_wait%0d_state", i), 32'(dbg_state), 32'(S_REQ));
            chk($sformatf("gd_wait%0d_addr", i), 32'(m_addr), 32'h3C0);
            chk($sformatf("gd_wait%0d_done", i), 32'(core_done), 32'd0);
        end
        m_grnt_ = 1'b0;
        step();
        chk("gd_as_after_grant", 32'(m_as_), 32'd0);
        m_rdy_ = 1'b0; m_rd_data = 32'h0BADF00D;
        step();
        chk("gd_done", 32'(core_done), 32'd1);
        chk("gd_rd_data", core_rd_data, 32'h0BADF00D);
        chk("gd_req_released", 32'(m_req_), 32'd1);
        chk("gd_addr_kept", 32'(m_addr), 32'h3C0);
        m_grnt_ = 1'b1; m_rdy_ = 1'b1;
        step();
        chk("gd_single_done", 32'(core_done), 32'd0);
        chk("gd_rereq_low", 32'(m_req_), 32'd0);
        chk("gd_rereq_addr", 32'(m_addr), 32'h777);
        core_req = 1'b0;
        m_grnt_ = 1'b0;
        step();
        m_rdy_ = 1'b0; m_rd_data = 32'h13579BDF;
        exp_q.push_back(32'h13579BDF);
        wait_done("gd_second", 4);
        drive_idle();
        step();

        // ---- reset asserted in WAIT ----
        start_txn(30'h100, 1'b0, 32'h600DCAFE);
        m_rdy_ = 1'b1;
        step();
        chk("rw_in_wait", 32'(dbg_state), 32'(S_WAIT));
        #2;
        reset = 1'b1;
        #1;
        chk("rw_req_", 32'(m_req_), 32'd1);
        chk("rw_as_", 32'(m_as_), 32'd1);
        chk("rw_busy", 32'(core_busy), 32'd0);
        chk("rw_done", 32'(core_done), 32'd0);
        chk("rw_addr", 32'(m_addr), 32'd0);
        step();
        chk("rw_done_hold", 32'(core_done), 32'd0);
        #2;
        reset = 1'b0;
        drive_idle();
        step();
        chk("rw_done_after", 32'(core_done), 32'd0);
        chk("rw_idle_after", 32'(dbg_state), 32'(S_IDLE));
        start_txn(30'h2468, 1'b1, 32'h0);
        m_rdy_ = 1'b0; m_rd_data = 32'h12345678;
        exp_q.push_back(32'h12345678);
        wait_done("rw_read", 3);
        chk("rw_read_err", 32'(core_err), 32'd0);
        drive_idle();
        step();

`ifdef BUS_TIMEOUT_EN
        // ---- timeout, ready never asserted ----
        start_txn(30'h0ABC, 1'b1, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("to_wait%0d_done", i), 32'(core_done), 32'd0);
            chk($sformatf("to_wait%0d_state", i), 32'(dbg_state), 32'(S_WAIT));
        end
        step();
        chk("to_done", 32'(core_done), 32'd1);
        chk("to_err", 32'(core_err), 32'd1);
        chk("to_rd_zero", core_rd_data, 32'd0);
        chk("to_req_", 32'(m_req_), 32'd1);
        chk("to_as_", 32'(m_as_), 32'd1);
        chk("to_busy", 32'(core_busy), 32'd0);
        m_grnt_ = 1'b1;
        step();
        chk("to_done_pulse", 32'(core_done), 32'd0);
        chk("to_err_pulse", 32'(core_err), 32'd0);

        // ---- ready on the final count cycle completes normally ----
        start_txn(30'h0DEF, 1'b1, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("tl_wait%0d_done", i), 32'(core_done), 32'd0);
        end
        m_rdy_ = 1'b0; m_rd_data = 32'hCAFEF00D;
        step();
        chk("tl_done", 32'(core_done), 32'd1);
        chk("tl_err", 32'(core_err), 32'd0);
        chk("tl_rd_data", core_rd_data, 32'hCAFEF00D);
`else
        // ---- without timeout, WAIT persists until ready ----
        start_txn(30'h0ABC, 1'b1, 32'h0);
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("nt_wait%0d_done", i), 32'(core_done), 32'd0);
            chk($sformatf("nt_wait%0d_state", i), 32'(dbg_state), 32'(S_WAIT));
        end
        m_rdy_ = 1'b0; m_rd_data = 32'hCAFEF00D;
        step();
        chk("nt_done", 32'(core_done), 32'd1);
        chk("nt_err", 32'(core_err), 32'd0);
        chk("nt_rd_data", core_rd_data, 32'hCAFEF00D);
`endif
        drive_idle();
        step();

        // ---- report ----
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
